// File: rtl/dsp_issue_ctrl.sv
// Issue/sequencing controller: pending-write scoreboard, multi-cycle op, memory and branch holds.
// Optional macro DSP_ISSUE_WB_BYPASS_EN lets a dependent instruction issue in its writeback cycle.
`ifndef ALU_ADD
`define ALU_ADD    8'h01
`endif
`ifndef ALU_MUL
`define ALU_MUL    8'h08
`endif
`ifndef ALU_MUL_I
`define ALU_MUL_I  8'h09
`endif
`ifndef ALU_IMUL
`define ALU_IMUL   8'h0A
`endif
`ifndef ALU_IMUL_I
`define ALU_IMUL_I 8'h0B
`endif
`ifndef ALU_SQR
`define ALU_SQR    8'h0C
`endif
`ifndef ALU_MAC
`define ALU_MAC    8'h0D
`endif
`ifndef MEM_NONE
`define MEM_NONE   3'd0
`endif
`ifndef MEM_LD
`define MEM_LD     3'd1
`endif
`ifndef FLOW_NONE
`define FLOW_NONE  3'd0
`endif
`ifndef FLOW_BEQ
`define FLOW_BEQ   3'd1
`endif

module dsp_issue_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int MUL_LAT      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [7:0]              alu_mode,
  input  logic                    r_w,
  input  logic [2:0]              mem_mode,
  input  logic [2:0]              flow_mode,
  input  logic [REG_ADDR_LEN-1:0] reg_s1,
  input  logic [REG_ADDR_LEN-1:0] reg_s2,
  input  logic [REG_ADDR_LEN-1:0] reg_dest,
  output logic                    ex_issue,
  output logic                    stall,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic                    br_resolve,
  input  logic                    br_taken,
  output logic                    flush,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_LEN-1:0] wb_reg,
  output logic [1:0]              state_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULB = 2'd1,
    MEMW = 2'd2,
    BRW  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] pend_chk;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                flush_q, flush_d;
  logic                hazard;

  function automatic logic is_mul_op(input logic [7:0] mode);
    case (mode)
      `ALU_MUL, `ALU_MUL_I, `ALU_IMUL, `ALU_IMUL_I, `ALU_SQR, `ALU_MAC: is_mul_op = 1'b1;
      default: is_mul_op = 1'b0;
    endcase
  endfunction

  always_comb begin
    pend_chk = pend_q;
`ifdef DSP_ISSUE_WB_BYPASS_EN
    if (wb_valid) pend_chk[wb_reg] = 1'b0;
`endif
    hazard    = pend_chk[reg_s1] | pend_chk[reg_s2] | (r_w & pend_chk[reg_dest]);
    dec_ready = (state_q == IDLE) & ~hazard & ~flush_q;
    ex_issue  = dec_valid & dec_ready;
    stall     = dec_valid & ~dec_ready;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    flush_d   = 1'b0;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (ex_issue) begin
          if (flow_mode != `FLOW_NONE) begin
            state_d = BRW;
          end else if (mem_mode != `MEM_NONE) begin
            state_d   = MEMW;
            mem_req_d = 1'b1;
          end else if (is_mul_op(alu_mode) && (MUL_LAT > 1)) begin
            state_d = MULB;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      MULB: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      MEMW: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      BRW: begin
        if (br_resolve) begin
          state_d = IDLE;
          flush_d = br_taken;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new pending write takes precedence over a same-cycle writeback to that register.
    if (wb_valid) pend_d[wb_reg] = 1'b0;
    if (ex_issue && r_w) pend_d[reg_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_req = mem_req_q;
  assign flush   = flush_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Directed, table-driven bench for dsp_issue_ctrl (default MUL_LAT=3).
`ifndef ALU_ADD
`define ALU_ADD    8'h01
`endif
`ifndef ALU_MUL
`define ALU_MUL    8'h08
`endif
`ifndef MEM_LD
`define MEM_LD     3'd1
`endif
`ifndef FLOW_BEQ
`define FLOW_BEQ   3'd1
`endif

module tb_dsp_issue_ctrl;

  logic       clk, rst;
  logic       dec_valid, dec_ready, r_w;
  logic [7:0] alu_mode;
  logic [2:0] mem_mode, flow_mode;
  logic [4:0] reg_s1, reg_s2, reg_dest, wb_reg;
  logic       ex_issue, stall, mem_req, mem_ack, br_resolve, br_taken, flush, wb_valid;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  dsp_issue_ctrl dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .alu_mode(alu_mode), .r_w(r_w), .mem_mode(mem_mode), .flow_mode(flow_mode),
    .reg_s1(reg_s1), .reg_s2(reg_s2), .reg_dest(reg_dest), .ex_issue(ex_issue),
    .stall(stall), .mem_req(mem_req), .mem_ack(mem_ack), .br_resolve(br_resolve),
    .br_taken(br_taken), .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [7:0] alu;
    logic       rw;
    logic [2:0] mem, flow;
    logic [4:0] s1, s2, dst;
    logic       ack, brr, brt, wbv;
    logic [4:0] wbr;
    logic       rdy, iss, stl, mreq, fl;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic dv, input logic [7:0] alu, input logic rw, input logic [2:0] mem,
    input logic [2:0] flow, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dst,
    input logic ack, input logic brr, input logic brt, input logic wbv, input logic [4:0] wbr,
    input logic rdy, input logic iss, input logic stl, input logic mreq, input logic fl,
    input logic [1:0] st);
    vec_t v;
    v.dv = dv; v.alu = alu; v.rw = rw; v.mem = mem; v.flow = flow;
    v.s1 = s1; v.s2 = s2; v.dst = dst; v.ack = ack; v.brr = brr; v.brt = brt;
    v.wbv = wbv; v.wbr = wbr; v.rdy = rdy; v.iss = iss; v.stl = stl;
    v.mreq = mreq; v.fl = fl; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_valid = v.dv; alu_mode = v.alu; r_w = v.rw; mem_mode = v.mem; flow_mode = v.flow;
    reg_s1 = v.s1; reg_s2 = v.s2; reg_dest = v.dst; mem_ack = v.ack;
    br_resolve = v.brr; br_taken = v.brt; wb_valid = v.wbv; wb_reg = v.wbr;
  endtask

  task automatic idle_in();
    drive(mk(0, 8'h00, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    drive(v);
    #2;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".dec_ready"}, {7'd0, dec_ready}, {7'd0, v.rdy});
    chk({tag, ".ex_issue"},  {7'd0, ex_issue},  {7'd0, v.iss});
    chk({tag, ".stall"},     {7'd0, stall},     {7'd0, v.stl});
    chk({tag, ".mem_req"},   {7'd0, mem_req},   {7'd0, v.mreq});
    chk({tag, ".flush"},     {7'd0, flush},     {7'd0, v.fl});
    chk({tag, ".state_o"},   {6'd0, state_o},   {6'd0, v.st});
    tick();
  endtask

  initial begin
    // Row fields: dv alu rw mem flow s1 s2 dst ack brr brt wbv wbr | rdy iss stl mreq fl st
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
`ifdef DSP_ISSUE_WB_BYPASS_EN
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 3, 1, 4, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 6, 7, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
`else
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 3, 1, 4, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
`endif
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    // multiply-class hold
    tbl.push_back(mk(1, `ALU_MUL, 0, 0, 0, 1, 2, 8, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 1, 2, 9, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // taken branch: the flush-cycle instruction (writes r10) must be dropped
    tbl.push_back(mk(1, 8'h00,    0, 0, `FLOW_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 1, 2, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 10, 1, 11, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // not-taken branch, then a stray resolve in IDLE
    tbl.push_back(mk(1, 8'h00,    0, 0, `FLOW_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 1, 2, 9, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // same-cycle set and writeback of r5: set wins
    tbl.push_back(mk(1, `ALU_ADD, 1, 0, 0, 1, 2, 5, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, `ALU_ADD, 0, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Load with ack held low for 4 cycles: mem_req for 5 cycles including the ack cycle
    drive(mk(1, 8'h00, 1, `MEM_LD, 0, 1, 2, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("ld.issue", {7'd0, ex_issue}, 8'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(mk(1, `ALU_ADD, 0, 0, 0, 1, 2, 9, (c == 4), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      chk($sformatf("ld.mem_req%0d", c), {7'd0, mem_req}, 8'd1);
      chk($sformatf("ld.ready%0d", c), {7'd0, dec_ready}, 8'd0);
      chk($sformatf("ld.state%0d", c), {6'd0, state_o}, 8'd2);
      tick();
    end
    drive(mk(1, `ALU_ADD, 0, 0, 0, 12, 2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("ld.after_req", {7'd0, mem_req}, 8'd0);
    chk("ld.after_state", {6'd0, state_o}, 8'd0);
    chk("ld.r12_pending", {7'd0, stall}, 8'd1);
    tick();

    // Reset while waiting on memory
    drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0));
    tick();
    drive(mk(1, 8'h00, 1, `MEM_LD, 0, 1, 2, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst.ld_issue", {7'd0, ex_issue}, 8'd1);
    tick();
    idle_in();
    #2;
    chk("rst.pre_req", {7'd0, mem_req}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(mk(1, `ALU_ADD, 1, 0, 0, 14, 2, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst.mem_req", {7'd0, mem_req}, 8'd0);
    chk("rst.state", {6'd0, state_o}, 8'd0);
    chk("rst.flush", {7'd0, flush}, 8'd0);
    chk("rst.ready", {7'd0, dec_ready}, 8'd1);
    chk("rst.issue", {7'd0, ex_issue}, 8'd1);
    tick();
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
